game_sequencer: RTL and testbench

GAME_SEQUENCER -- requirements
Module: game_sequencer

---
 rtl/game_sequencer.sv | 178 +++++++++++++++++
 tb/tb_game_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// Round sequencer for the flappy-style game: IDLE -> COUNTDOWN -> PLAY -> DYING -> OVER.
// All outputs are registered and respond one clk_25MHz cycle after the qualifying input.
module game_sequencer #(
  parameter int unsigned COUNT_FRAMES = 60,
  parameter int unsigned DEATH_FRAMES = 90
) (
  input  logic       clk_25MHz,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       flap_btn,
  input  logic       lose,
  input  logic [9:0] score,
  output logic [2:0] state,
  output logic       game_start,
  output logic       freeze,
  output logic       flap_out,
  output logic       round_reset,
  output logic [1:0] countdown,
  output logic [9:0] high_score,
  output logic       new_record,
  output logic [1:0] speed_level
);

  localparam int unsigned MAX_FRAMES = (COUNT_FRAMES > DEATH_FRAMES) ? COUNT_FRAMES : DEATH_FRAMES;
  localparam int unsigned CNT_W      = ($clog2(MAX_FRAMES + 1) > 8) ? $clog2(MAX_FRAMES + 1) : 8;

  localparam logic [CNT_W:0] COUNT_LIM = (CNT_W + 1)'(COUNT_FRAMES);
  localparam logic [CNT_W:0] DEATH_LIM = (CNT_W + 1)'(DEATH_FRAMES);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_PLAY      = 3'd2,
    S_DYING     = 3'd3,
    S_OVER      = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_prev_q, flap_prev_q;
  logic             game_start_q, game_start_d;
  logic             freeze_q, freeze_d;
  logic             flap_out_q, flap_out_d;
  logic             round_reset_q, round_reset_d;
  logic [1:0]       countdown_q, countdown_d;
  logic [9:0]       high_score_q, high_score_d;
  logic             new_record_q, new_record_d;
  logic [1:0]       speed_level_q, speed_level_d;

  logic             start_press, flap_press;
  logic [CNT_W:0]   cnt_inc;
  logic [CNT_W-1:0] cnt_sat;
  logic             step_done, death_done;

  function automatic logic [1:0] speed_of(input logic [9:0] s);
    if (s >= 10'd30)      return 2'd3;
    else if (s >= 10'd15) return 2'd2;
    else if (s >= 10'd5)  return 2'd1;
    else                  return 2'd0;
  endfunction

  assign start_press = start_btn & ~start_prev_q;
  assign flap_press  = flap_btn  & ~flap_prev_q;

  // Extra bit on the increment lets the limit compare see past the saturated value.
  assign cnt_inc    = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign cnt_sat    = (&cnt_q) ? cnt_q : cnt_inc[CNT_W-1:0];
  assign step_done  = frame_tick && (cnt_inc >= COUNT_LIM);
  assign death_done = frame_tick && (cnt_inc >= DEATH_LIM);

  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      start_prev_q  <= 1'b1;
      flap_prev_q   <= 1'b1;
      game_start_q  <= 1'b0;
      freeze_q      <= 1'b0;
      flap_out_q    <= 1'b0;
      round_reset_q <= 1'b0;
      countdown_q   <= '0;
      high_score_q  <= '0;
      new_record_q  <= 1'b0;
      speed_level_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      start_prev_q  <= start_btn;
      flap_prev_q   <= flap_btn;
      game_start_q  <= game_start_d;
      freeze_q      <= freeze_d;
      flap_out_q    <= flap_out_d;
      round_reset_q <= round_reset_d;
      countdown_q   <= countdown_d;
      high_score_q  <= high_score_d;
      new_record_q  <= new_record_d;
      speed_level_q <= speed_level_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (start_press) state_d = S_COUNTDOWN;
      S_COUNTDOWN: if (step_done && (countdown_q == 2'd1)) state_d = S_PLAY;
      S_PLAY:      if (lose) state_d = S_DYING;
      S_DYING:     if (death_done) state_d = S_OVER;
      S_OVER:      if (start_press) state_d = S_COUNTDOWN;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d         = cnt_q;
    countdown_d   = countdown_q;
    high_score_d  = high_score_q;
    new_record_d  = new_record_q;
    speed_level_d = speed_level_q;
    flap_out_d    = 1'b0;
    round_reset_d = 1'b0;

    case (state_q)
      S_IDLE, S_OVER: begin
        // A start press takes priority; flap is never acted on outside PLAY.
        if (start_press) begin
          cnt_d         = '0;
          countdown_d   = 2'd3;
          round_reset_d = 1'b1;
          if (state_q == S_OVER) begin
            new_record_d  = 1'b0;
            speed_level_d = '0;
          end
        end
      end
      S_COUNTDOWN: begin
        if (step_done) begin
          cnt_d       = '0;
          countdown_d = countdown_q - 2'd1;
        end else if (frame_tick) begin
          cnt_d = cnt_sat;
        end
      end
      S_PLAY: begin
        speed_level_d = speed_of(score);
        if (lose) begin
          cnt_d = '0;
          if (score > high_score_q) begin
            high_score_d = score;
            new_record_d = 1'b1;
          end
        end else if (flap_press) begin
          flap_out_d = 1'b1;
        end
      end
      S_DYING: begin
        if (frame_tick) cnt_d = cnt_sat;
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase

    game_start_d = (state_d == S_PLAY);
    freeze_d     = (state_d == S_DYING) || (state_d == S_OVER);
  end

  assign state       = state_q;
  assign game_start  = game_start_q;
  assign freeze      = freeze_q;
  assign flap_out    = flap_out_q;
  assign round_reset = round_reset_q;
  assign countdown   = countdown_q;
  assign high_score  = high_score_q;
  assign new_record  = new_record_q;
  assign speed_level = speed_level_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed round scenarios plus randomized play,
// every cycle compared against a tick-count reference model.
module tb_game_sequencer;

  localparam int CF = 2;
  localparam int DF = 3;

  logic       clk_25MHz = 1'b0;
  logic       reset;
  logic       frame_tick, start_btn, flap_btn, lose;
  logic [9:0] score;
  logic [2:0] state;
  logic       game_start, freeze, flap_out, round_reset, new_record;
  logic [1:0] countdown, speed_level;
  logic [9:0] high_score;

  game_sequencer #(.COUNT_FRAMES(CF), .DEATH_FRAMES(DF)) dut (
    .clk_25MHz  (clk_25MHz),
    .reset      (reset),
    .frame_tick (frame_tick),
    .start_btn  (start_btn),
    .flap_btn   (flap_btn),
    .lose       (lose),
    .score      (score),
    .state      (state),
    .game_start (game_start),
    .freeze     (freeze),
    .flap_out   (flap_out),
    .round_reset(round_reset),
    .countdown  (countdown),
    .high_score (high_score),
    .new_record (new_record),
    .speed_level(speed_level)
  );

  always #20 clk_25MHz = ~clk_25MHz;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase numbers follow the published state values; progress
  // is tracked as total frame ticks since the phase began.
  int m_phase, m_ticks, m_hs, m_nr, m_spd, m_flap, m_rr;
  bit m_sprev, m_fprev;

  function automatic int speed_of(input int s);
    if (s >= 30) return 3;
    if (s >= 15) return 2;
    if (s >= 5)  return 1;
    return 0;
  endfunction

  function automatic int m_digit();
    return (m_phase == 1) ? 3 - m_ticks / CF : 0;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_ticks = 0; m_hs = 0; m_nr = 0; m_spd = 0;
    m_flap = 0; m_rr = 0; m_sprev = 1'b1; m_fprev = 1'b1;
  endtask

  task automatic new_round();
    m_phase = 1; m_ticks = 0; m_rr = 1;
  endtask

  task automatic model_step(input bit s, input bit f, input bit l, input bit t, input int sc);
    bit sp, fp;
    sp = s && !m_sprev;
    fp = f && !m_fprev;
    m_sprev = s;
    m_fprev = f;
    m_flap = 0;
    m_rr = 0;
    case (m_phase)
      0: if (sp) new_round();
      1: if (t) begin
           m_ticks++;
           if (m_ticks >= 3 * CF) m_phase = 2;
         end
      2: begin
           m_spd = speed_of(sc);
           if (l) begin
             m_phase = 3;
             m_ticks = 0;
             if (sc > m_hs) begin m_hs = sc; m_nr = 1; end
           end else if (fp) m_flap = 1;
         end
      3: if (t) begin
           m_ticks++;
           if (m_ticks >= DF) m_phase = 4;
         end
      4: if (sp) begin new_round(); m_nr = 0; m_spd = 0; end
      default: m_phase = 0;
    endcase
  endtask

  task automatic check_outputs();
    check_eq("state", int'(state), m_phase);
    check_eq("game_start", int'(game_start), int'(m_phase == 2));
    check_eq("freeze", int'(freeze), int'(m_phase >= 3));
    check_eq("flap_out", int'(flap_out), m_flap);
    check_eq("round_reset", int'(round_reset), m_rr);
    check_eq("countdown", int'(countdown), m_digit());
    check_eq("high_score", int'(high_score), m_hs);
    check_eq("new_record", int'(new_record), m_nr);
    check_eq("speed_level", int'(speed_level), m_spd);
  endtask

  task automatic cycle(input bit s, input bit f, input bit l, input bit t, input int sc);
    start_btn = s; flap_btn = f; lose = l; frame_tick = t; score = sc[9:0];
    @(posedge clk_25MHz);
    model_step(s, f, l, t, sc);
    #1 check_outputs();
  endtask

  task automatic ticks(input int n, input int sc);
    for (int i = 0; i < n; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b1, sc);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, sc);
    end
  endtask

  // Asserted mid-cycle so the checks see the reset values with no clock edge.
  task automatic async_reset_pulse();
    #4 reset = 1'b1;
    model_reset();
    #1 check_outputs();
    #5 reset = 1'b0;
  endtask

  task automatic start_round(input int sc);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, sc);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, sc);
    ticks(3 * CF, sc);
  endtask

  int pulses;
  int spd_score[5] = '{4, 5, 14, 15, 30};
  int spd_exp[5]   = '{0, 1, 1, 2, 3};

  initial begin
    bit rs, rf, rl, rt;
    int rsc;
    reset = 1'b1; start_btn = 1'b1; flap_btn = 1'b0; lose = 1'b0;
    frame_tick = 1'b0; score = '0;
    model_reset();
    @(posedge clk_25MHz);
    @(posedge clk_25MHz);
    #1 check_outputs();
    #4 reset = 1'b0;

    // Start held through reset release is not a press.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 0);
    check_eq("held_start_idle", int'(state), 0);
    cycle(1'b0, 1'b0, 1'b0, 0, 0);

    cycle(1'b1, 1'b0, 1'b0, 1'b0, 0);
    check_eq("start_state", int'(state), 1);
    check_eq("start_digit", int'(countdown), 3);
    check_eq("start_rr", int'(round_reset), 1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 0);
    check_eq("rr_one_cycle", int'(round_reset), 0);
    ticks(2, 0);
    check_eq("digit_after2", int'(countdown), 2);
    ticks(2, 0);
    check_eq("digit_after4", int'(countdown), 1);
    ticks(2, 0);
    check_eq("play_state", int'(state), 2);
    check_eq("play_gs", int'(game_start), 1);
    check_eq("play_digit", int'(countdown), 0);

    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 3);
      pulses += int'(flap_out);
    end
    check_eq("flap_pulses", pulses, 1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 3);

    cycle(1'b0, 1'b1, 1'b1, 1'b0, 7);
    check_eq("lose_state", int'(state), 3);
    check_eq("lose_noflap", int'(flap_out), 0);
    check_eq("hs_first", int'(high_score), 7);
    check_eq("nr_first", int'(new_record), 1);
    check_eq("lose_freeze", int'(freeze), 1);
    ticks(3, 7);
    check_eq("over_state", int'(state), 4);

    cycle(1'b1, 1'b0, 1'b0, 1'b0, 7);
    check_eq("r2_nr_clear", int'(new_record), 0);
    check_eq("r2_spd_clear", int'(speed_level), 0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 7);
    ticks(3 * CF, 7);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 7);
    check_eq("hs_equal_hold", int'(high_score), 7);
    check_eq("nr_equal_hold", int'(new_record), 0);
    ticks(3, 7);

    start_round(0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, spd_score[i]);
      check_eq("speed_step", int'(speed_level), spd_exp[i]);
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 12);
    check_eq("hs_third", int'(high_score), 12);
    ticks(3, 12);

    start_round(20);
    check_eq("pre_reset_play", int'(state), 2);
    async_reset_pulse();
    check_eq("async_state", int'(state), 0);
    check_eq("async_hs", int'(high_score), 0);

    rs = 1'b0; rf = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) rs = ~rs;
      if ($urandom_range(0, 2) == 0) rf = ~rf;
      rt = 1'($urandom_range(0, 1));
      rl = (m_phase == 2) ? ($urandom_range(0, 15) == 0) : 1'($urandom_range(0, 1));
      rsc = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 40));
      cycle(rs, rf, rl, rt, rsc);
      if ($urandom_range(0, 399) == 0) async_reset_pulse();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
